btb_predictor: RTL

Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating direction counters for the 16-bit pipelined datapath. The IF stage looks it up combinationally with the fetch PC to choose the next PC. The ID stage writes back the resolved branch/jump outcome one update per cycle. The block also flags mispredictions and keeps saturating statistics counters.

---
 rtl/btb_predictor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with combinational lookup,
// one resolved-branch update per cycle, mispredict detection and saturating
// statistics counters.
// Optional feature macro: BTB_COUNTER_EN
//   defined   -> per-entry 2-bit saturating direction counters
//   undefined -> hit implies taken; a not-taken update on a hit invalidates the entry
module btb_predictor #(
  parameter int unsigned WORD     = 16,
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [WORD-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [WORD-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [WORD-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [WORD-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [WORD-1:0] upd_pred_next_pc,
  output logic            mispredict,
  output logic [WORD-1:0] correct_pc,
  output logic [WORD-1:0] upd_count,
  output logic [WORD-1:0] mispred_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS;
  localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS - 1;

  // Index and tag must both fit inside the PC.
  generate
    if (IDX_BITS + TAG_BITS > WORD) begin : g_bad_cfg
      $error("btb_predictor: IDX_BITS + TAG_BITS must not exceed WORD");
    end
  endgenerate

  // Table state, all flops.
  logic [ENTRIES-1:0]               valid_q,  valid_d;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q,    tag_d;
  logic [ENTRIES-1:0][WORD-1:0]     target_q, target_d;
`ifdef BTB_COUNTER_EN
  logic [ENTRIES-1:0][1:0]          ctr_q,    ctr_d;
`endif

  // Statistics.
  logic [WORD-1:0] upd_count_q, upd_count_d;
  logic [WORD-1:0] mispred_count_q, mispred_count_d;

  // Lookup and update decode.
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [WORD-1:0]     actual_next_pc;

  // The carried direction is implied by the carried next PC, so it is not consulted.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  // Combinational IF-stage lookup from current table contents (read-before-write).
  always_comb begin
    lk_idx       = pred_pc[IDX_BITS-1:0];
    lk_tag       = pred_pc[TAG_MSB:TAG_LSB];
    pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
`ifdef BTB_COUNTER_EN
    pred_taken   = pred_hit && ctr_q[lk_idx][1];
`else
    pred_taken   = pred_hit;
`endif
    pred_next_pc = pred_taken ? target_q[lk_idx] : WORD'(pred_pc + WORD'(1));
  end

  // Resolved outcome versus carried prediction; redirect target always driven.
  always_comb begin
    actual_next_pc = upd_taken ? upd_target : WORD'(upd_pc + WORD'(1));
    correct_pc     = actual_next_pc;
    mispredict     = upd_valid && (actual_next_pc != upd_pred_next_pc);
  end

  // Next-state for table entries from the ID-stage update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
`ifdef BTB_COUNTER_EN
    ctr_d    = ctr_q;
`endif
    up_idx   = upd_pc[IDX_BITS-1:0];
    up_tag   = upd_pc[TAG_MSB:TAG_LSB];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (upd_valid) begin
`ifdef BTB_COUNTER_EN
      if (up_hit && upd_taken) begin
        if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = 2'(ctr_q[up_idx] + 2'd1);
        target_d[up_idx] = upd_target;
      end else if (up_hit) begin
        if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = 2'(ctr_q[up_idx] - 2'd1);
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = 2'b10;
      end
`else
      if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
      end else if (up_hit) begin
        valid_d[up_idx]  = 1'b0;
      end
`endif
    end
  end

  // Saturating statistics counters.
  always_comb begin
    upd_count_d     = upd_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid && (upd_count_q != '1)) upd_count_d = WORD'(upd_count_q + WORD'(1));
    if (mispredict && (mispred_count_q != '1)) mispred_count_d = WORD'(mispred_count_q + WORD'(1));
  end

  // State registers; reset clears the whole table in one cycle and drops any update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q         <= '0;
      tag_q           <= '0;
      target_q        <= '0;
`ifdef BTB_COUNTER_EN
      ctr_q           <= {ENTRIES{2'b01}};
`endif
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
`ifdef BTB_COUNTER_EN
      ctr_q           <= ctr_d;
`endif
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign upd_count     = upd_count_q;
  assign mispred_count = mispred_count_q;

endmodule
